// File: rtl/alu_pkg.sv
// Shared definitions for the ALU round-robin arbiter.
// Opcode map, result-register states and datapath width.
package alu_pkg;

    localparam int DATA_W = 8;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_SHR  = 4'h2;
    localparam logic [3:0] OP_SHL  = 4'h3;
    localparam logic [3:0] OP_ROR  = 4'h4;
    localparam logic [3:0] OP_ROL  = 4'h5;
    localparam logic [3:0] OP_AND  = 4'h6;
    localparam logic [3:0] OP_OR   = 4'h7;
    localparam logic [3:0] OP_NOT  = 4'h8;
    localparam logic [3:0] OP_XOR  = 4'h9;
    localparam logic [3:0] OP_LAST = 4'h9;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    // Opcodes past the end of the map are accepted but flagged.
    function automatic logic op_illegal(input logic [3:0] op);
        return op > OP_LAST;
    endfunction

endpackage

// File: rtl/alu_rr_arbiter_alu.sv
// Shared 8-bit combinational ALU.
// Shift/rotate amounts of 8 or more are saturated explicitly.
module alu_rr_arbiter_alu
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [3:0]        op,
    output logic [DATA_W-1:0] f
);

    logic                  big;
    logic [2*DATA_W-1:0]   rr;
    logic [2*DATA_W-1:0]   rl;

    // Rotates are taken from a doubled copy of A.
    always_comb begin
        big = |b[DATA_W-1:3];
        rr  = {a, a} >> b[2:0];
        rl  = {a, a} << b[2:0];
    end

    // Opcode decode; unknown opcodes yield zero.
    always_comb begin
        f = '0;
        unique case (op)
            OP_ADD: f = a + b;
            OP_SUB: f = a - b;
            OP_SHR: f = big ? '0 : (a >> b[2:0]);
            OP_SHL: f = big ? '0 : (a << b[2:0]);
            OP_ROR: f = big ? a : rr[DATA_W-1:0];
            OP_ROL: f = big ? a : rl[2*DATA_W-1:DATA_W];
            OP_AND: f = a & b;
            OP_OR:  f = a | b;
            OP_NOT: f = ~a;
            OP_XOR: f = a ^ b;
            default: f = '0;
        endcase
    end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Two-requester round-robin front end for the shared ALU.
// The winner's result lands in a one-entry output register.
module alu_rr_arbiter #(
    parameter int TAG_W  = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [3:0]        req0_op,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [TAG_W-1:0]  req0_tag,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [3:0]        req1_op,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [TAG_W-1:0]  req1_tag,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_src,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic              rsp_err,
    output logic              busy
);

    import alu_pkg::state_t;
    import alu_pkg::ST_EMPTY;
    import alu_pkg::ST_FULL;
    import alu_pkg::op_illegal;

    state_t            state;
    state_t            state_next;
    logic              last_grant;
    logic              grant;
    logic              can_accept;
    logic              accept;
    logic [3:0]        sel_op;
    logic [DATA_W-1:0] sel_a;
    logic [DATA_W-1:0] sel_b;
    logic [TAG_W-1:0]  sel_tag;
    logic [DATA_W-1:0] alu_f;
    logic              sel_err;

    assign rsp_valid = (state == ST_FULL);
    assign busy      = rsp_valid;

    // Pick the winner: a lone requester, else the one not served last.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid)
            grant = ~last_grant;
        else if (req1_valid)
            grant = 1'b1;
    end

    // Handshake: the register must be empty or draining on this edge.
    always_comb begin
        can_accept = !rsp_valid || rsp_ready;
        req0_ready = !rst && can_accept && req0_valid && !grant;
        req1_ready = !rst && can_accept && req1_valid && grant;
        accept     = req0_ready || req1_ready;
    end

    // Steer the granted requester's operands into the ALU.
    always_comb begin
        sel_op  = grant ? req1_op  : req0_op;
        sel_a   = grant ? req1_a   : req0_a;
        sel_b   = grant ? req1_b   : req0_b;
        sel_tag = grant ? req1_tag : req0_tag;
        sel_err = op_illegal(sel_op);
    end

    alu_rr_arbiter_alu u_alu (
        .a  (sel_a),
        .b  (sel_b),
        .op (sel_op),
        .f  (alu_f)
    );

    // Result register occupancy.
    always_comb begin
        state_next = state;
        unique case (state)
            ST_EMPTY: if (accept) state_next = ST_FULL;
            ST_FULL:  if (rsp_ready && !accept) state_next = ST_EMPTY;
            default:  state_next = ST_EMPTY;
        endcase
    end

    // Occupancy register; reset drops any pending result.
    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_EMPTY;
        else
            state <= state_next;
    end

    // Remember who was served so ties alternate.
    always_ff @(posedge clk) begin
        if (rst)
            last_grant <= 1'b1;
        else if (accept)
            last_grant <= grant;
    end

    // Capture the result on acceptance; otherwise hold bit-stable.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_data <= '0;
            rsp_src  <= 1'b0;
            rsp_tag  <= '0;
            rsp_err  <= 1'b0;
        end else if (accept) begin
            rsp_data <= sel_err ? '0 : alu_f;
            rsp_src  <= grant;
            rsp_tag  <= sel_tag;
            rsp_err  <= sel_err;
        end
    end

endmodule

// File: doc/alu_rr_arbiter.md
Name: alu_rr_arbiter

Overview:
Two-requester round-robin arbiter that shares the team's single 8-bit combinational ALU (opcodes 0000–1001).
- Each requester presents an operation over a valid/ready handshake.
- The winner's operands drive the ALU, and the result is captured in a one-entry output register with its own valid/ready handshake.
- Sits between issuing engines (e.g. a microsequencer and a DMA checksum unit) and downstream consumers.

Parameters:
TAG_W, 4, width of the requester-supplied tag echoed with the result
DATA_W, 8, operand/result width; fixed at 8 to match the ALU, other values unsupported

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  requester 0 operation accepted this cycle
req0_op  in  4  ALU opcode
req0_a  in  8  operand A
req0_b  in  8  operand B
req0_tag  in  TAG_W  requester tag
req1_valid / req1_ready / req1_op / req1_a / req1_b / req1_tag  same as requester 0
rsp_valid  out  1  result register holds a result
rsp_ready  in  1  consumer takes result this cycle
rsp_data  out  8  ALU result
rsp_src  out  1  index of requester that issued it
rsp_tag  out  TAG_W  echoed tag
rsp_err  out  1  opcode was outside 0000–1001
busy  out  1  equals rsp_valid (result pending)

Behaviour:
- Handshake rules:
  - Transfer occurs when valid && ready on the same edge.
  - Requesters hold op/a/b/tag stable while valid && !ready.
  - reqX_ready may depend combinationally on req valids and rsp_ready.
- can_accept = !rsp_valid || rsp_ready. The output register is empty, or is drained on this edge.
- Grant:
  - Exactly one valid requester: it is granted.
  - Both valid: grant the requester not recorded in last_grant.
  - reqX_ready = can_accept && reqX_valid && (grant == X). At most one ready is high per cycle.
- last_grant updates to the accepted index on every acceptance. No update without acceptance.
- FSM states:
  - EMPTY (rsp_valid=0), FULL (rsp_valid=1).
  - EMPTY + accept -> FULL.
  - FULL + rsp_ready + accept -> FULL, with new contents loaded in the same cycle.
  - FULL + rsp_ready + no accept -> EMPTY.
  - FULL + !rsp_ready -> FULL, with all rsp_* held bit-stable.
- Latency and throughput:
  - Accept on edge N gives rsp_valid=1 after edge N, i.e. one cycle.
  - With rsp_ready held high, throughput is one operation per cycle.
- ALU semantics (8-bit, result truncated mod 256):
  - 0000 add; 0001 sub (wraps).
  - 0010 A>>B; 0011 A<<B (shift amount B≥8 gives 0).
  - 0100 rotate right; 0101 rotate left (B≥8 returns A unchanged, B=0 returns A).
  - 0110 and; 0111 or; 1000 not A (B ignored); 1001 xor.
  - Opcodes 1010–1111 are accepted normally, with rsp_data=0x00 and rsp_err=1.
- Fairness: with both valids held high and rsp_ready=1, grants alternate strictly 0,1,0,1… No requester waits more than one acceptance slot.
- Reset:
  - rsp_valid=0, rsp_data=0x00, rsp_src=0, rsp_tag=0, rsp_err=0, busy=0.
  - last_grant=1, so requester 0 wins the first tie.
  - Both req_ready=0 during the rst cycle.
  - A result pending when reset asserts is discarded, never presented.
  - A request with valid high during the reset cycle is not accepted.
- Simultaneous drain and accept: the new result replaces the drained one with no bubble cycle.

Decomposition:
- Shared package alu_pkg:
  - Opcode constants OP_ADD=4'h0 … OP_XOR=4'h9 and OP_LAST=4'h9.
  - State encoding ST_EMPTY/ST_FULL.
  - DATA_W.
- One sub-module: the existing combinational ALU, instantiated unchanged.
  - Its A/B/instruction inputs are muxed from the granted requester.
  - Its output F, plus an err bit computed as op > OP_LAST, is registered into rsp_*.

Test Plan:
1. Only req0_valid, op=0000 A=0xF0 B=0x20 tag=3 -> req0_ready=1 that cycle; next cycle rsp_valid=1 data=0x10 src=0 tag=3 err=0.
2. Both valid continuously, rsp_ready=1; req0 op=0100 A=0x81 B=1, req1 op=0101 A=0x81 B=9 -> after reset, responses alternate src 0,1,0,1 with data 0xC0, 0x81, 0xC0, 0x81.
3. Backpressure: rsp_valid=1, rsp_ready=0 for 3 cycles with both reqs valid -> both req_ready=0, rsp_* stable. Raise rsp_ready -> drain and accept on the same edge, next result valid the following cycle.
4. Illegal opcode 1100 A=0x12 B=0x34 from req1 -> rsp_data=0x00 rsp_err=1 src=1; arbitration unaffected.
5. Boundaries: op=0011 A=0xFF B=8 -> 0x00; op=0001 A=0x00 B=0x01 -> 0xFF; op=1000 A=0x5A B=0xFF -> 0xA5.
6. Assert rst for one cycle while rsp_valid=1 and both reqs valid -> rsp_valid=0 and outputs zero after the reset edge; first post-reset tie is granted to req0.
